// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-high, bit 0 = segment a.
package seg7_pkg;

    typedef enum logic {
        BLANK,
        DRIVE
    } phase_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n is the pattern for hex digit n (index 15 first).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5e, 7'h39,
        7'h7c, 7'h77, 7'h67, 7'h7f,
        7'h07, 7'h7d, 7'h6d, 7'h66,
        7'h4f, 7'h5b, 7'h06, 7'h3f
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: value/strobe from the producer, pin-level outputs back.
// The producer side is the master; the scan driver is the slave.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output hex_in, dp_in, en_in, load,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  hex_in, dp_in, en_in, load,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to seven-segment lookup (active-high).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with frame-coherent updates.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HEX_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    phase_e                phase_q, phase_d;

    logic [HEX_W-1:0]      hex_pend_q, hex_pend_d;
    logic [NUM_DIGITS-1:0] dp_pend_q, dp_pend_d;
    logic [NUM_DIGITS-1:0] en_pend_q, en_pend_d;
    logic [HEX_W-1:0]      hex_act_q, hex_act_d;
    logic [NUM_DIGITS-1:0] dp_act_q, dp_act_d;
    logic [NUM_DIGITS-1:0] en_act_q, en_act_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic                  frame_go;
    logic [3:0]            nib;
    logic [6:0]            dec_seg;
    logic                  dp_sel;
    logic                  en_sel;
    logic                  sup_sel;
    logic                  show;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [NUM_DIGITS-1:0] supp;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            phase_d = BLANK;
        end else if (cnt_q == BLANK_LAST) begin
            phase_d = DRIVE;
        end
    end

    // Active bank only changes at the top of digit 0's slot.
    assign frame_go = (cnt_q == '0) && (idx_q == '0);

    always_comb begin
        hex_pend_d = bus.load ? bus.hex_in : hex_pend_q;
        dp_pend_d  = bus.load ? bus.dp_in  : dp_pend_q;
        en_pend_d  = bus.load ? bus.en_in  : en_pend_q;
        hex_act_d  = frame_go ? hex_pend_q : hex_act_q;
        dp_act_d   = frame_go ? dp_pend_q  : dp_act_q;
        en_act_d   = frame_go ? en_pend_q  : en_act_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the MSB; the chain breaks at the first shown enabled digit.
    always_comb begin
        logic chain;
        supp  = '0;
        chain = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            supp[k] = chain && (k != 0) && !dp_act_q[k]
                      && (hex_act_q[4*k +: 4] == 4'h0);
            if (en_act_q[k] && !supp[k]) begin
                chain = 1'b0;
            end
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        nib     = 4'h0;
        dp_sel  = 1'b0;
        en_sel  = 1'b0;
        sup_sel = 1'b0;
        an_sel  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib       = hex_act_q[4*k +: 4];
                dp_sel    = dp_act_q[k];
                en_sel    = en_act_q[k];
                sup_sel   = supp[k];
                an_sel[k] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        show  = (phase_q == DRIVE) && en_sel && !sup_sel;
        seg_d = (show ? dec_seg : SEG_OFF) ^ {7{SEG_INV}};
        dp_d  = (show && dp_sel) ^ SEG_INV;
        an_d  = (show ? an_sel : '0) ^ {NUM_DIGITS{AN_INV}};
        fs_d  = frame_go;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            phase_q    <= BLANK;
            hex_pend_q <= '0;
            dp_pend_q  <= '0;
            en_pend_q  <= '0;
            hex_act_q  <= '0;
            dp_act_q   <= '0;
            en_act_q   <= '0;
            seg_q      <= SEG_OFF ^ {7{SEG_INV}};
            dp_q       <= SEG_INV;
            an_q       <= {NUM_DIGITS{AN_INV}};
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            hex_pend_q <= hex_pend_d;
            dp_pend_q  <= dp_pend_d;
            en_pend_q  <= en_pend_d;
            hex_act_q  <= hex_act_d;
            dp_act_q   <= dp_act_d;
            en_act_q   <= en_act_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank).
// Expected pin values come from frame/slot arithmetic on the elapsed cycle count.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int SDIV  = 8;
    localparam int BLNK  = 2;
    localparam int FRAME = N * SDIV;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SDIV),
        .BLANK_CYC      (BLNK),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    logic [6:0] lut [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h67, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    // Reference state: cycles since reset release, plus the two banks.
    int          s = 0;
    logic [15:0] p_hex = '0, a_hex = '0;
    logic [3:0]  p_dp = '0, a_dp = '0, p_en = '0, a_en = '0;

    function automatic logic [3:0] nib(input logic [15:0] h, input int k);
        return h[4*k +: 4];
    endfunction

    function automatic bit suppressed(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 0 || nib(a_hex, k) != 4'h0 || a_dp[k]) return 1'b0;
        for (int j = k + 1; j < N; j++)
            if (a_en[j] && !suppressed(j)) return 1'b0;
        return 1'b1;
`else
        return (k < 0);
`endif
    endfunction

    initial begin
        forever begin
            exp_t e;
            int   p, d, c;
            bit   show;
            @(posedge clk);
            e.seg = 7'h00; e.dp = 1'b0; e.an = 4'hF; e.fs = 1'b0;
            if (rst) begin
                s = 0;
                p_hex = '0; a_hex = '0;
                p_dp = '0; a_dp = '0; p_en = '0; a_en = '0;
            end else begin
                p = s % FRAME;
                d = p / SDIV;
                c = p % SDIV;
                if (p == 0) begin
                    a_hex = p_hex; a_dp = p_dp; a_en = p_en;
                end
                if (bus.load) begin
                    p_hex = bus.hex_in; p_dp = bus.dp_in; p_en = bus.en_in;
                end
                e.fs = (p == 0);
                show = (c >= BLNK) && a_en[d] && !suppressed(d);
                if (show) begin
                    e.seg = lut[nib(a_hex, d)];
                    e.dp  = a_dp[d];
                    e.an  = ~(4'b0001 << d);
                end
                s++;
            end
            q.push_back(e);
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.seg !== e.seg || bus.dp !== e.dp ||
                    bus.an !== e.an || bus.frame_start !== e.fs) begin
                    failures++;
                    $display("FAIL pins t=%0t got seg=%h dp=%b an=%h fs=%b want seg=%h dp=%b an=%h fs=%b",
                             $time, bus.seg, bus.dp, bus.an, bus.frame_start,
                             e.seg, e.dp, e.an, e.fs);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] dpv,
                           input logic [3:0] env);
        bus.hex_in = h; bus.dp_in = dpv; bus.en_in = env; bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    // Wait until the next edge will be frame position pos.
    task automatic wait_pos(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (s % FRAME == pos) return;
            step(1);
        end
        failures++;
        $display("FAIL wait_pos timeout pos=%0d at=%0d", pos, s % FRAME);
    endtask

    initial begin
        bus.hex_in = '0; bus.dp_in = '0; bus.en_in = '0; bus.load = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        do_load(16'h1234, 4'b0100, 4'hF);
        step(2 * FRAME + 8);
        wait_pos(12);
        do_load(16'hABCD, 4'b0000, 4'hF);
        step(FRAME + 4);
        wait_pos(0);
        do_load(16'h5A5A, 4'b1001, 4'hF);
        step(FRAME - 1);
        wait_pos(1);
        do_load(16'h6789, 4'b0010, 4'h7);
        step(2 * FRAME);
        do_load(16'h0050, 4'b0000, 4'hF);
        step(2 * FRAME + 4);
        wait_pos(2 * SDIV + 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2 * FRAME);
        for (int it = 0; it < 40; it++) begin
            logic [15:0] h;
            step($urandom_range(0, 40));
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                h = 16'($urandom);
                if ($urandom_range(0, 1) == 1) h = h & (16'hFFFF >> (4 * $urandom_range(1, 3)));
                do_load(h, 4'($urandom), 4'($urandom_range(0, 15) | 1));
            end
        end
        step(2 * FRAME + 4);
        if (checks < 12) begin
            failures++;
            $display("FAIL check_count got=%0d want>=12", checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display bank. It latches a packed hex word plus per-digit decimal-point and enable bits, and scans one digit at a time at a fixed slot length. Each slot opens with an anti-ghosting blank interval, and display updates are frame-coherent. It sits between the datapath/FSM that produces display values and the board's segment/anode pins, and replaces per-digit static hex decoders.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned; at least 1.
- SCAN_DIV, 100000: clock cycles per digit slot; at least 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < SCAN_DIV.
- SEG_ACTIVE_LOW, 0: when 1, invert seg and dp at the pins.
- AN_ACTIVE_LOW, 1: when 1, a digit is selected by driving its an bit 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- hex_in  in  4*NUM_DIGITS  digit values; digit k = hex_in[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- en_in  in  NUM_DIGITS  per-digit enable, 0 = blank digit.
- load  in  1  strobe; samples hex_in/dp_in/en_in into the pending registers.
- seg  out  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
- dp  out  1  decimal-point segment.
- an  out  NUM_DIGITS  digit select.
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- Decode of active-high patterns (bit0=a), before polarity:
  - 0:3f, 1:06, 2:5b, 3:4f, 4:66, 5:6d, 6:7d, 7:07
  - 8:7f, 9:67, A:77, b:7c, C:39, d:5e, E:79, F:71
- Register banks: pending (hex, dp, en) and active (hex, dp, en).
- A load cycle copies the inputs into pending. Back-to-back loads: the last one wins.
- Pending is copied into active on the cycle frame_start is asserted. Only the active bank drives the pins, so a frame never mixes old and new values.
- Scan state:
  - slot counter cnt: 0..SCAN_DIV-1.
  - digit index idx: 0..NUM_DIGITS-1; wraps to 0 after NUM_DIGITS-1.
  - phase: BLANK while cnt < BLANK_CYC, otherwise DRIVE.
- Transitions:
  - cnt == SCAN_DIV-1 → cnt=0, idx advances, phase = BLANK.
  - cnt == BLANK_CYC-1 → phase = DRIVE.
- BLANK phase: all an inactive; seg and dp show all segments off.
- DRIVE phase:
  - an selects idx (one-hot, polarity applied).
  - seg = decode(active hex[idx]); dp = active dp[idx].
  - If active en[idx]=0, the anode stays inactive and seg/dp are off.
- NUM_DIGITS=1: idx is constant 0; frame_start fires every slot.
- Reset:
  - cnt=0, idx=0, phase BLANK.
  - Both banks cleared (hex 0, dp 0, en 0).
  - an all inactive; seg and dp all off (polarity applied); frame_start=0.
  - A reset mid-slot or mid-frame abandons the slot; the pending load is lost.
- load asserted in the same cycle as frame_start: active takes the previous pending contents; the new value is applied at the next frame.

## Timing
- All outputs are registered, with one cycle from the counter state to the pins.
- First frame_start pulse: the first cycle after rst deasserts.
- DRIVE outputs appear at cycle BLANK_CYC+1 of a slot and hold for SCAN_DIV-BLANK_CYC cycles.
- Frame period: NUM_DIGITS*SCAN_DIV cycles.
- Worst-case latency from load to pins: one frame plus BLANK_CYC+1 cycles.
- Widths:
  - cnt is $clog2(SCAN_DIV) bits; idx is max(1,$clog2(NUM_DIGITS)) bits.
  - No arithmetic overflow: both counters compare against terminal values before wrapping.

## Configuration
- LEADING_ZERO_BLANK_EN defined: in DRIVE phase, a digit is suppressed when all of these hold:
  - its active hex is 0, its dp is 0, and it is not digit 0;
  - every more-significant enabled digit is also a suppressed zero.
  Suppression is evaluated on the active bank and uses the same blank output as en=0.
- Undefined: zeros are always displayed; enables alone control blanking.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry pattern constant;
  - SEG_OFF (7'h00);
  - the phase enum {BLANK, DRIVE}.
- One sub-module: seg7_decode, a combinational 4→7 lookup on the package constant; instantiated once and fed by the idx-selected nibble.
- Polarity inversion is applied only at the output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- Reset held 3 cycles, then released → an=4'hF, seg=0, dp=0 during reset; frame_start pulses on the 1st cycle after release; period is 32 cycles.
- load hex_in=16'h1234, en_in=4'hF, dp_in=4'b0100 → next frame, DRIVE phases give (an=E, seg=66), (an=D, seg=4f), (an=B, seg=5b, dp=1), (an=7, seg=06); each lasts 6 cycles, preceded by 2 blank cycles.
- load 16'hABCD at mid-frame → the remaining digits of the current frame still show 1234; the next frame shows 77, 7c, 39, 5e from the MSB digit.
- load asserted coincident with frame_start → that frame shows the old value; the new value appears one frame later.
- LEADING_ZERO_BLANK_EN defined, load 16'h0050, en=4'hF → digits 3 and 2 are blanked (an inactive); digits 1 and 0 show 6d and 3f. Undefined: all four show 3f, 3f, 6d, 3f.
- rst asserted mid-DRIVE of digit 2 → next cycle all outputs are off; the active bank is cleared, so all digits stay blank until a new load.
